// File: rtl/stage3_result_collector.sv
// Stage-3 FC result collector: captures one frame of class scores,
// tracks the running argmax and hands the winner to the host link.
module stage3_result_collector #(
    parameter int NUM_CLASS = 3,
    parameter int VAL_BW    = 20,
    parameter int IDX_BW    = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic signed [VAL_BW-1:0] i_value,
    input  logic [IDX_BW-1:0]        i_index,
    output logic                     o_result_valid,
    input  logic                     i_result_ready,
    output logic [IDX_BW-1:0]        o_class_idx,
    output logic signed [VAL_BW-1:0] o_max_value,
    output logic                     o_err,
    output logic                     o_overrun,
    input  logic [IDX_BW-1:0]        i_rd_addr,
    output logic signed [VAL_BW-1:0] o_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_CLASS - 1);
    localparam bit SINGLE = (NUM_CLASS == 1);

    state_t state, state_nxt;

    logic signed [VAL_BW-1:0] scores [NUM_CLASS];
    logic signed [VAL_BW-1:0] best_val;
    logic [IDX_BW-1:0]        best_idx;
    logic [IDX_BW-1:0]        exp_idx;

    logic start, cont, bad, drop, done, take, wr_en;
    logic signed [VAL_BW-1:0] cand_val;
    logic [IDX_BW-1:0]        cand_idx;

    // Classify the incoming beat against the current state
    always_comb begin
        start = 1'b0;
        cont  = 1'b0;
        bad   = 1'b0;
        drop  = 1'b0;
        unique case (state)
            IDLE: begin
                start = i_valid && (i_index == '0);
                bad   = i_valid && (i_index != '0);
            end
            COLLECT: begin
                cont = i_valid && (i_index == exp_idx);
                bad  = i_valid && (i_index != exp_idx);
            end
            HOLD: begin
                start = i_valid && i_result_ready && (i_index == '0);
                bad   = i_valid && i_result_ready && (i_index != '0);
                drop  = i_valid && !i_result_ready;
            end
            default: ;
        endcase
    end

    // Running argmax candidate; strict compare keeps the lowest index on ties
    always_comb begin
        wr_en    = start || cont;
        done     = (cont && (i_index == LAST_IDX)) || (start && SINGLE);
        take     = cont && (i_value > best_val);
        cand_val = best_val;
        cand_idx = best_idx;
        if (start) begin
            cand_val = i_value;
            cand_idx = '0;
        end else if (take) begin
            cand_val = i_value;
            cand_idx = i_index;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = SINGLE ? HOLD : COLLECT;
            end
            COLLECT: begin
                if (done)     state_nxt = HOLD;
                else if (bad) state_nxt = IDLE;
            end
            HOLD: begin
                if (i_result_ready)
                    state_nxt = start ? (SINGLE ? HOLD : COLLECT) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_result_valid = (state == HOLD);
    end

    // Score buffer, argmax tracking, result latch and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_val    <= '0;
            best_idx    <= '0;
            exp_idx     <= '0;
            o_class_idx <= '0;
            o_max_value <= '0;
            o_err       <= 1'b0;
            o_overrun   <= 1'b0;
            for (int k = 0; k < NUM_CLASS; k++) scores[k] <= '0;
        end else begin
            o_err <= bad;
            if (drop) o_overrun <= 1'b1;
            if (wr_en) begin
                best_val <= cand_val;
                best_idx <= cand_idx;
                if (done)       exp_idx <= '0;
                else if (start) exp_idx <= IDX_BW'(1);
                else            exp_idx <= exp_idx + IDX_BW'(1);
            end else if (bad) begin
                exp_idx <= '0;
            end
            if (done) begin
                o_class_idx <= cand_idx;
                o_max_value <= cand_val;
            end
            for (int k = 0; k < NUM_CLASS; k++)
                if (wr_en && (i_index == IDX_BW'(k))) scores[k] <= i_value;
        end
    end

    // Combinational readback; out-of-range addresses read as zero
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_CLASS; k++)
            if (i_rd_addr == IDX_BW'(k)) o_rd_data = scores[k];
    end

endmodule

// File: tb/tb_stage3_result_collector.sv
// Directed bench for stage3_result_collector (NUM_CLASS=3, VAL_BW=20).
// Expected results are hand-computed per vector.
module tb_stage3_result_collector;

    localparam int NC = 3;
    localparam int VW = 20;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 i_valid;
    logic signed [VW-1:0] i_value;
    logic [IW-1:0]        i_index;
    logic                 o_result_valid;
    logic                 i_result_ready;
    logic [IW-1:0]        o_class_idx;
    logic signed [VW-1:0] o_max_value;
    logic                 o_err;
    logic                 o_overrun;
    logic [IW-1:0]        i_rd_addr;
    logic signed [VW-1:0] o_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    stage3_result_collector #(
        .NUM_CLASS(NC),
        .VAL_BW(VW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_valid(i_valid),
        .i_value(i_value),
        .i_index(i_index),
        .o_result_valid(o_result_valid),
        .i_result_ready(i_result_ready),
        .o_class_idx(o_class_idx),
        .o_max_value(o_max_value),
        .o_err(o_err),
        .o_overrun(o_overrun),
        .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int idx, input int val);
        i_valid = 1'b1;
        i_index = IW'(idx);
        i_value = VW'(val);
        cyc();
        i_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int idx, input int val);
        chk({tag, ".rv"}, {31'd0, o_result_valid}, 1);
        chk({tag, ".idx"}, {30'd0, o_class_idx}, idx);
        chk({tag, ".val"}, $signed(o_max_value), val);
    endtask

    task automatic rd(input string tag, input int addr, input int val);
        i_rd_addr = IW'(addr);
        #1;
        chk(tag, $signed(o_rd_data), val);
    endtask

    initial begin
        reset          = 1'b1;
        i_valid        = 1'b0;
        i_value        = '0;
        i_index        = '0;
        i_result_ready = 1'b0;
        i_rd_addr      = '0;
        repeat (2) cyc();
        chk("rst.rv", {31'd0, o_result_valid}, 0);
        chk("rst.idx", {30'd0, o_class_idx}, 0);
        chk("rst.val", $signed(o_max_value), 0);
        chk("rst.err", {31'd0, o_err}, 0);
        chk("rst.ovr", {31'd0, o_overrun}, 0);
        rd("rst.rd1", 1, 0);
        reset = 1'b0;
        cyc();

        // Basic contiguous frame, ready held high
        i_result_ready = 1'b1;
        put(0, 5);
        put(1, -3);
        chk("f1.notyet", {31'd0, o_result_valid}, 0);
        put(2, 12);
        chk_res("f1", 2, 12);
        rd("f1.rd1", 1, -3);
        cyc();
        chk("f1.drop", {31'd0, o_result_valid}, 0);
        i_result_ready = 1'b0;

        // Ties and negatives
        put(0, 7);
        put(1, 7);
        put(2, -1);
        chk_res("tie", 0, 7);
        rd("tie.rd2", 2, -1);
        cyc();
        chk_res("tie.hold", 0, 7);
        i_result_ready = 1'b1;
        cyc();
        chk("tie.ack", {31'd0, o_result_valid}, 0);
        i_result_ready = 1'b0;

        // Gapped frame
        put(0, -10);
        repeat (2) cyc();
        put(1, -2);
        repeat (2) cyc();
        put(2, -30);
        chk_res("gap", 1, -2);
        i_result_ready = 1'b1;
        cyc();
        i_result_ready = 1'b0;

        // Sequence error then clean frame
        put(0, 4);
        put(2, 9);
        chk("seq.err", {31'd0, o_err}, 1);
        chk("seq.rv", {31'd0, o_result_valid}, 0);
        cyc();
        chk("seq.err1", {31'd0, o_err}, 0);
        chk("seq.rv1", {31'd0, o_result_valid}, 0);
        put(0, 1);
        put(1, 2);
        put(2, 3);
        chk_res("seq.ok", 2, 3);
        i_result_ready = 1'b1;
        cyc();
        i_result_ready = 1'b0;

        // Backpressure and overrun
        put(0, -5);
        put(1, 20);
        put(2, 6);
        chk_res("bp", 1, 20);
        chk("bp.ovr0", {31'd0, o_overrun}, 0);
        put(0, 100);
        chk("bp.ovr1", {31'd0, o_overrun}, 1);
        repeat (3) cyc();
        chk_res("bp.held", 1, 20);
        rd("bp.rd0", 0, -5);
        i_result_ready = 1'b1;
        cyc();
        chk("bp.ack", {31'd0, o_result_valid}, 0);
        chk("bp.sticky", {31'd0, o_overrun}, 1);
        i_result_ready = 1'b0;

        // Ready together with a new index-0 beat in HOLD
        put(0, 1);
        put(1, -1);
        put(2, 0);
        chk_res("sim", 0, 1);
        i_result_ready = 1'b1;
        put(0, -8);
        i_result_ready = 1'b0;
        chk("sim.ack", {31'd0, o_result_valid}, 0);
        put(1, -9);
        put(2, -7);
        chk_res("sim2", 2, -7);
        rd("sim2.rd0", 0, -8);

        // Ready together with a bad beat in HOLD
        i_result_ready = 1'b1;
        put(1, 0);
        i_result_ready = 1'b0;
        chk("simbad.rv", {31'd0, o_result_valid}, 0);
        chk("simbad.err", {31'd0, o_err}, 1);

        // Reset mid-frame
        put(0, 50);
        put(1, 60);
        reset = 1'b1;
        #2;
        chk("mrst.rv", {31'd0, o_result_valid}, 0);
        chk("mrst.val", $signed(o_max_value), 0);
        chk("mrst.idx", {30'd0, o_class_idx}, 0);
        chk("mrst.ovr", {31'd0, o_overrun}, 0);
        rd("mrst.rd1", 1, 0);
        reset = 1'b0;
        cyc();
        put(0, 3);
        put(1, 9);
        put(2, 9);
        chk_res("post", 1, 9);
        rd("post.rd3", 3, 0);
        rd("post.rd2", 2, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
